// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction prefetch queue: FSM states, queue entry, PC step.
package fetch_queue_pkg;
  localparam int PC_STEP    = 2;
  localparam int FQ_ADDR_W  = 16;
  localparam int FQ_INSTR_W = 16;

  typedef enum logic [1:0] {IDLE, WAIT, DROP, HALT} fetch_state_e;

  typedef struct packed {
    logic [FQ_ADDR_W-1:0]  pc;
    logic [FQ_INSTR_W-1:0] instr;
  } fq_entry_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry FIFO of {pc, instr} with flush; head is read straight from storage.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fq_entry_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  entry_t        entry_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [CW-1:0] count_o,
  output entry_t        head_o
);
  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= entry_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (pop_i) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
endmodule

// File: rtl/fetch_queue.sv
// Prefetch stage: sequential req/ack fetches into a FIFO, flushed on redirect.
// Optional statistics outputs enabled by FETCH_QUEUE_STATS_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int ADDR_W  = 16,
  parameter int INSTR_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               halt_sys_i,
  input  logic               redirect_i,
  input  logic [ADDR_W-1:0]  redirect_addr_i,
  output logic               imem_req_o,
  output logic [ADDR_W-1:0]  imem_addr_o,
  input  logic               imem_ack_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic               out_valid_o,
  output logic [INSTR_W-1:0] out_instr_o,
  output logic [ADDR_W-1:0]  out_pc_o,
  input  logic               out_ready_i
`ifdef FETCH_QUEUE_STATS_EN
  ,
  output logic [15:0]        flush_count_o,
  output logic [15:0]        empty_cycles_o
`endif
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } entry_t;

  fetch_state_e      state_q;
  logic [ADDR_W-1:0] fetch_pc_q, imem_addr_q;
  logic              imem_req_q;
  logic [CW-1:0]     count, count_d;
  entry_t            head, push_entry;
  logic              redir, push, pop;
  logic [ADDR_W-1:0] pc_inc, redir_pc;

  assign redir      = redirect_i && (state_q != HALT);
  assign push       = (state_q == WAIT) && imem_ack_i && !redir;
  assign out_valid_o = (count != '0);
  assign pop        = out_valid_o && out_ready_i && !redir;
  assign count_d    = count + CW'(push) - CW'(pop);
  assign pc_inc     = fetch_pc_q + ADDR_W'(PC_STEP);
  assign redir_pc   = redirect_addr_i & ~ADDR_W'(1);
  assign push_entry = '{pc: fetch_pc_q, instr: imem_data_i};

  fetch_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (pop),
    .flush_i (redir),
    .count_o (count),
    .head_o  (head)
  );

  // Credit is taken at issue: a request only goes out while a slot is free,
  // and nothing else pushes while it is outstanding.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      fetch_pc_q  <= '0;
      imem_req_q  <= 1'b0;
      imem_addr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (redir) fetch_pc_q <= redir_pc;
          else if (halt_sys_i) state_q <= HALT;
          else if (count < CW'(DEPTH)) begin
            imem_req_q  <= 1'b1;
            imem_addr_q <= fetch_pc_q;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (redir) begin
            fetch_pc_q <= redir_pc;
            if (imem_ack_i) begin
              imem_req_q <= 1'b0;
              state_q    <= IDLE;
            end else state_q <= DROP;
          end else if (imem_ack_i) begin
            fetch_pc_q <= pc_inc;
            if (!halt_sys_i && count_d < CW'(DEPTH)) imem_addr_q <= pc_inc;
            else begin
              imem_req_q <= 1'b0;
              state_q    <= halt_sys_i ? HALT : IDLE;
            end
          end
        end
        DROP: begin
          if (redir) fetch_pc_q <= redir_pc;
          if (imem_ack_i) begin
            imem_req_q <= 1'b0;
            state_q    <= IDLE;
          end
        end
        default: imem_req_q <= 1'b0;
      endcase
    end
  end

  assign imem_req_o  = imem_req_q;
  assign imem_addr_o = imem_addr_q;
  assign out_instr_o = head.instr;
  assign out_pc_o    = head.pc;

`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] flush_cnt_q, empty_cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flush_cnt_q <= '0;
      empty_cnt_q <= '0;
    end else if (state_q != HALT) begin
      if (redir && (count != '0 || state_q == WAIT || state_q == DROP))
        flush_cnt_q <= sat_inc16(flush_cnt_q);
      if (!out_valid_o) empty_cnt_q <= sat_inc16(empty_cnt_q);
    end
  end
  assign flush_count_o  = flush_cnt_q;
  assign empty_cycles_o = empty_cnt_q;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Random + directed bench for fetch_queue against a queue-based reference model.
module tb_fetch_queue;
  logic        clk = 0, rst_n = 0;
  logic        halt_sys = 0, redirect = 0, imem_ack = 0, out_ready = 0;
  logic [15:0] redirect_addr = 0, imem_data = 0;
  logic        imem_req, out_valid;
  logic [15:0] imem_addr, out_instr, out_pc;
`ifdef FETCH_QUEUE_STATS_EN
  logic [15:0] flush_count, empty_cycles;
`endif

  fetch_queue dut (
    .clk_i(clk), .rst_ni(rst_n), .halt_sys_i(halt_sys), .redirect_i(redirect),
    .redirect_addr_i(redirect_addr), .imem_req_o(imem_req), .imem_addr_o(imem_addr),
    .imem_ack_i(imem_ack), .imem_data_i(imem_data), .out_valid_o(out_valid),
    .out_instr_o(out_instr), .out_pc_o(out_pc), .out_ready_i(out_ready)
`ifdef FETCH_QUEUE_STATS_EN
    , .flush_count_o(flush_count), .empty_cycles_o(empty_cycles)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [15:0] pc; logic [15:0] instr; } ent_t;
  ent_t        q[$];
  int          checks = 0, errors = 0;
  int          lat = 0, wcnt = 0, pops = 0, n_redir = 0;
  bit          drop_pend = 0, halt_v = 0, got;
  logic [15:0] mpc = 0, held_addr = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, act, exp);
    end
  endtask

  // One cycle: memory model answers, inputs applied, model advanced, edge, valid checked.
  // rdm: 0 no redirect, 1 redirect, 2 redirect only if memory acks this cycle.
  task automatic cyc(input bit rdy, input int rdm, input logic [15:0] ra);
    bit          ack_now, rd;
    logic [15:0] d;
    ack_now = 0;
    if (imem_req) begin
      if (wcnt == 0) held_addr = imem_addr;
      else chk("addr_stable", imem_addr, held_addr);
      if (wcnt >= lat) begin ack_now = 1; wcnt = 0; end
      else wcnt++;
    end else wcnt = 0;
    rd = (rdm == 1) || (rdm == 2 && ack_now);
    d  = 16'($urandom);
    imem_ack = ack_now; imem_data = d; out_ready = rdy;
    redirect = rd; redirect_addr = ra; halt_sys = halt_v;
    if (out_valid && rdy && !rd) begin
      if (q.size() == 0) chk("pop_empty", out_valid, 0);
      else begin
        chk("pop_pc", out_pc, q[0].pc);
        chk("pop_instr", out_instr, q[0].instr);
        void'(q.pop_front());
        pops++;
      end
    end
    if (ack_now) begin
      if (rd || drop_pend) drop_pend = 0;
      else begin
        chk("fetch_addr", imem_addr, mpc);
        chk("no_ovf", q.size() < 4, 1);
        q.push_back('{mpc, d});
        mpc = mpc + 16'd2;
      end
    end
    if (rd) begin
      n_redir++;
      q.delete();
      mpc = ra & 16'hFFFE;
      if (imem_req && !ack_now) drop_pend = 1;
    end
    @(posedge clk); #1;
    imem_ack = 0; redirect = 0;
    chk("valid", out_valid, q.size() != 0);
  endtask

  task automatic do_reset();
    rst_n = 0; halt_v = 0; halt_sys = 0; imem_ack = 0; redirect = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_instr", out_instr, 0);
    q.delete(); mpc = 0; drop_pend = 0; wcnt = 0;
    rst_n = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: zero-wait memory, one entry per cycle
    do_reset(); lat = 0;
    repeat (4) cyc(1, 0, 0);
    pops = 0;
    repeat (16) cyc(1, 0, 0);
    chk("throughput", pops, 16);

    // 2: stalled decode fills the queue, fetch resumes at 0x0008
    do_reset(); lat = 1;
    repeat (14) cyc(0, 0, 0);
    chk("full_req", imem_req, 0);
    got = 0;
    for (int i = 0; i < 6 && !got; i++) begin
      cyc(1, 0, 0);
      if (imem_req) begin got = 1; chk("resume_addr", imem_addr, 16'h0008); end
    end
    if (!got) chk("resume_req", imem_req, 1);
    repeat (10) cyc(1, 0, 0);

    // 3: redirect in 2nd wait cycle, in-flight word dropped
    do_reset(); lat = 3;
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 16'h0040);
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      cyc(1, 0, 0);
      if (out_valid) begin got = 1; chk("redir_pc", out_pc, 16'h0040); end
    end
    if (!got) chk("redir_valid", out_valid, 1);

    // 4: redirect coinciding with ack, two entries queued
    do_reset(); lat = 1; n_redir = 0;
    for (int i = 0; i < 30 && n_redir == 0; i++) cyc(0, (q.size() == 2) ? 2 : 0, 16'h0040);
    chk("redir_ack_seen", n_redir, 1);
    got = 0;
    for (int i = 0; i < 5 && !got; i++) begin
      if (imem_req) begin got = 1; chk("reissue_addr", imem_addr, 16'h0040); end
      else cyc(0, 0, 0);
    end
    if (!got) chk("reissue_req", imem_req, 1);
    repeat (10) cyc(1, 0, 0);

    // 5: PC wrap
    do_reset(); lat = 0;
    cyc(1, 1, 16'hFFFD);
    for (int i = 0; i < 10 && !out_valid; i++) cyc(1, 0, 0);
    chk("wrap0", out_pc, 16'hFFFC); cyc(1, 0, 0);
    chk("wrap1", out_pc, 16'hFFFE); cyc(1, 0, 0);
    chk("wrap2", out_pc, 16'h0000); cyc(1, 0, 0);

    // 6a: halt during an outstanding request
    do_reset(); lat = 3;
    cyc(0, 0, 0);
    halt_v = 1;
    repeat (6) cyc(0, 0, 0);
    chk("halt_req", imem_req, 0);
    chk("halt_valid", out_valid, 1);
    repeat (4) cyc(1, 0, 0);
    chk("halt_req2", imem_req, 0);

    // 6b: reset asserted mid-WAIT clears outputs without a clock edge
    do_reset(); lat = 1;
    cyc(0, 1, 16'h0100);
    for (int i = 0; i < 20 && !(q.size() >= 2 && imem_req); i++) cyc(0, 0, 0);
    chk("pre_rst_req", imem_req, 1);
    rst_n = 0; #1;
    chk("arst_req", imem_req, 0);
    chk("arst_addr", imem_addr, 0);
    chk("arst_valid", out_valid, 0);
    chk("arst_pc", out_pc, 0);
    chk("arst_instr", out_instr, 0);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) lat = $urandom_range(0, 3);
      cyc($urandom_range(0, 3) != 0,
          ($urandom_range(0, 15) == 0) ? 1 : (($urandom_range(0, 31) == 0) ? 2 : 0),
          16'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
